prog_ctr: RTL and testbench

//  Program-counter stage of the 9-bit CPU; consumes the signed jump offset produced by the branch

---
 rtl/prog_ctr.sv | 89 ++++++++
 tb/tb_prog_ctr.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/prog_ctr.sv
// Program-counter stage: holds the instruction address, steps or branches it while running,
// and counts retired instructions between Start and Halt.
module prog_ctr #(
    parameter int             D          = 12,
    parameter logic [D-1:0]   START_ADDR = '0,
    parameter int             CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Stall,
    input  logic             BranchEn,
    input  logic [D-1:0]     Target,
    input  logic             Halt,
    output logic [D-1:0]     ProgCtr,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] InstCnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [D-1:0]     pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             running_q, running_d;
    logic             done_q, done_d;

    // Retire counter sticks at all-ones so long runs never alias to small counts.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_d = S_RUN;
                    pc_d    = START_ADDR;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (!Stall) begin
                    cnt_d = cnt_inc;
                    if (Halt) begin
                        state_d = S_DONE;
                    end else if (BranchEn) begin
                        // Equal widths make the add identical to a sign-extended modular add.
                        pc_d = pc_q + Target;
                    end else begin
                        pc_d = pc_q + D'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign ProgCtr = pc_q;
    assign Running = running_q;
    assign Done    = done_q;
    assign InstCnt = cnt_q;

endmodule

// File: tb/tb_prog_ctr.sv
// Bench for prog_ctr: directed vector table, hand sequences for saturation and mid-run reset,
// then randomized traffic checked against an arithmetic run-control model.
module tb_prog_ctr;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0, Stall = 1'b0, BranchEn = 1'b0, Halt = 1'b0;
    logic [11:0] Target = '0;
    logic [11:0] pc_a, pc_b;
    logic        run_a, run_b, done_a, done_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int tests = 0;
    int failed = 0;

    // Reference model: mode 0=idle, 1=run, 2=done; raw retire count is unbounded.
    int m_mode, m_pc, m_cnt;

    prog_ctr #(.D(12), .CNT_W(16)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall), .BranchEn(BranchEn),
        .Target(Target), .Halt(Halt), .ProgCtr(pc_a), .Running(run_a), .Done(done_a),
        .InstCnt(cnt_a)
    );

    prog_ctr #(.D(12), .CNT_W(4)) dut_sat (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall), .BranchEn(BranchEn),
        .Target(Target), .Halt(Halt), .ProgCtr(pc_b), .Running(run_b), .Done(done_b),
        .InstCnt(cnt_b)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit st, sl, br;
        int tg;
        bit hl;
        int pc;
        bit run, done;
        int cnt;
    } vec_t;

    vec_t vq[$];

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input bit st, input bit sl, input bit br, input int tg, input bit hl,
                       input int pc, input bit run, input bit done, input int cnt);
        vec_t v;
        v.st = st; v.sl = sl; v.br = br; v.tg = tg; v.hl = hl;
        v.pc = pc; v.run = run; v.done = done; v.cnt = cnt;
        vq.push_back(v);
    endtask

    task automatic model_step(input bit st, input bit sl, input bit br, input int tg, input bit hl);
        if (m_mode == 1) begin
            if (!sl) begin
                m_cnt++;
                if (hl)      m_mode = 2;
                else if (br) m_pc = (((m_pc + tg) % 4096) + 4096) % 4096;
                else         m_pc = (m_pc + 1) % 4096;
            end
        end else if (st) begin
            m_mode = 1;
            m_pc   = 0;
            m_cnt  = 0;
        end
    endtask

    task automatic step(input bit st, input bit sl, input bit br, input int tg, input bit hl);
        Start = st; Stall = sl; BranchEn = br; Target = tg[11:0]; Halt = hl;
        @(posedge Clk);
        #1;
        model_step(st, sl, br, tg, hl);
    endtask

    task automatic check_model(input string tag);
        check({tag, " pc"},      int'(pc_a),   m_pc);
        check({tag, " running"}, int'(run_a),  (m_mode == 1) ? 1 : 0);
        check({tag, " done"},    int'(done_a), (m_mode == 2) ? 1 : 0);
        check({tag, " cnt"},     int'(cnt_a),  min_i(m_cnt, 65535));
        check({tag, " pc4"},     int'(pc_b),   m_pc);
        check({tag, " cnt4"},    int'(cnt_b),  min_i(m_cnt, 15));
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        Start = 0; Stall = 0; BranchEn = 0; Target = '0; Halt = 0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        m_mode = 0; m_pc = 0; m_cnt = 0;
    endtask

    initial begin
        // st sl br tg hl | pc run done cnt
        add(0, 0, 1,   5, 1,    0, 0, 0, 0);   // idle ignores branch/halt
        add(1, 0, 0,   0, 0,    0, 1, 0, 0);
        for (int i = 1; i <= 10; i++) add(0, 0, 0, 0, 0, i, 1, 0, i);
        add(0, 0, 1, -41, 0, 4065, 1, 0, 11);  // backward wrap below zero
        add(0, 0, 1,  51, 0,   20, 1, 0, 12);  // forward wrap past top
        add(0, 0, 1,  50, 0,   70, 1, 0, 13);
        for (int i = 0; i < 3; i++) add(0, 1, 1, 9, 1, 70, 1, 0, 13);
        add(0, 0, 1,   0, 0,   70, 1, 0, 14);
        add(0, 0, 1, -63, 0,    7, 1, 0, 15);
        add(0, 0, 0,   0, 1,    7, 0, 1, 16);
        add(0, 0, 1,   3, 0,    7, 0, 1, 16);
        add(1, 0, 0,   0, 0,    0, 1, 0, 0);
        add(1, 0, 0,   0, 0,    1, 1, 0, 1);   // Start while running is ignored
        add(0, 0, 1,  -2, 0, 4095, 1, 0, 2);
        add(0, 0, 0,   0, 0,    0, 1, 0, 3);
        add(0, 0, 1,  -1, 0, 4095, 1, 0, 4);
        add(0, 0, 0,   0, 0,    0, 1, 0, 5);

        do_reset();
        #1;
        check("reset pc",      int'(pc_a),   0);
        check("reset running", int'(run_a),  0);
        check("reset done",    int'(done_a), 0);
        check("reset cnt",     int'(cnt_a),  0);

        foreach (vq[i]) begin
            step(vq[i].st, vq[i].sl, vq[i].br, vq[i].tg, vq[i].hl);
            check($sformatf("vec%0d pc", i),      int'(pc_a),   vq[i].pc);
            check($sformatf("vec%0d running", i), int'(run_a),  int'(vq[i].run));
            check($sformatf("vec%0d done", i),    int'(done_a), int'(vq[i].done));
            check($sformatf("vec%0d cnt", i),     int'(cnt_a),  vq[i].cnt);
            check($sformatf("vec%0d cnt4", i),    int'(cnt_b),  min_i(vq[i].cnt, 15));
        end

        // Saturation of the narrow counter after 20 retires.
        step(0, 0, 1, 0, 1);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0, 0);
            check_model($sformatf("sat%0d", i));
        end
        check("sat cnt4 final", int'(cnt_b), 15);
        check("sat cnt16 final", int'(cnt_a), 20);

        // Asynchronous reset in the middle of a cycle while running at PC=33.
        step(0, 0, 1, 13, 0);
        check("pre-reset pc", int'(pc_a), 33);
        #3;
        Reset_n = 1'b0;
        #1;
        check("async pc",      int'(pc_a),  0);
        check("async running", int'(run_a), 0);
        check("async cnt",     int'(cnt_a), 0);
        m_mode = 0; m_pc = 0; m_cnt = 0;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        check("held reset running", int'(run_a), 0);
        #2;
        Start = 1'b0;
        Reset_n = 1'b1;
        step(0, 0, 0, 0, 0);
        check_model("release");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit st, sl, br, hl;
            int tg;
            sl = ($urandom_range(0, 99) < 20);
            st = !sl && ($urandom_range(0, 99) < 10);
            hl = ($urandom_range(0, 99) < 5);
            br = ($urandom_range(0, 99) < 35);
            tg = int'($urandom_range(0, 4095));
            if (tg > 2047) tg -= 4096;
            step(st, sl, br, tg, hl);
            check_model($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
